adder_chunked: RTL and testbench

Parametrised multi-cycle ripple adder for the partition/approximation flow. It computes `{cout, sum} = a + b + cin` over WIDTH bits, CHUNK bits per clock. Each chunk's carry is registered into the next chunk, so the critical path stays one CHUNK-bit ripple for any WIDTH. Valid/ready handshakes sit on input and output, so it can be placed between streaming stages. An optional lower-part-OR mode makes the low bits approximate for accuracy/area studies.

---
 rtl/adder_chunked_pkg.sv | 21 ++
 rtl/adder_chunk_slice.sv | 26 ++
 rtl/adder_chunked.sv | 149 ++++++++++++++
 tb/tb_adder_chunked.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_chunked_pkg.sv
// adder_chunked_pkg: shared types and elaboration helpers for the chunked adder.
package adder_chunked_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices that make up a WIDTH-bit operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal geometry: width and approximate region both tile exactly into chunks.
  function automatic bit cfg_ok(input int width, input int chunk, input int approx_bits);
    return (chunk > 0) && (width % chunk == 0) &&
           (approx_bits % chunk == 0) && (approx_bits < width);
  endfunction

endpackage

// File: rtl/adder_chunk_slice.sv
// adder_chunk_slice: combinational CHUNK-bit ripple-carry adder, reused every cycle.
module adder_chunk_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  // Bit-serial ripple; this is the only carry chain in the whole adder.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[CHUNK];
  end

endmodule

// File: rtl/adder_chunked.sv
// adder_chunked: multi-cycle adder, {cout,sum} = a + b + cin, one CHUNK per clock.
// The carry between chunks is registered, so the timing path is one CHUNK ripple.
// Optional macro ADDER_CHUNKED_APPROX_LSB_EN: the low APPROX_BITS become a|b with
// no carry propagation except the top approximate chunk, and cin is ignored.
module adder_chunked
  import adder_chunked_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CHUNK       = 4,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (!cfg_ok(WIDTH, CHUNK, APPROX_BITS)) begin : g_cfg_err
      $error("adder_chunked: WIDTH and APPROX_BITS must be multiples of CHUNK, APPROX_BITS < WIDTH");
    end
  endgenerate

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic             in_ready_q, out_valid_q;

  int               base;
  logic [CHUNK-1:0] a_sl, b_sl, s_x, s_d;
  logic             co_x, co_d, carry_init;
  logic [WIDTH-1:0] sum_d;

  // Select the active slice of the captured operands.
  always_comb begin
    base = int'(cnt_q) * CHUNK;
    a_sl = a_q[base +: CHUNK];
    b_sl = b_q[base +: CHUNK];
  end

  adder_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry_q),
    .s  (s_x),
    .co (co_x)
  );

`ifdef ADDER_CHUNKED_APPROX_LSB_EN
  localparam int NAPX    = APPROX_BITS / CHUNK;
  localparam int APX_TOP = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;

  // Low chunks are OR-ed; only the top approximate chunk seeds a carry upward.
  always_comb begin
    s_d  = s_x;
    co_d = co_x;
    if (int'(cnt_q) < NAPX) begin
      s_d  = a_sl | b_sl;
      co_d = (int'(cnt_q) == NAPX - 1) ? (a_q[APX_TOP] & b_q[APX_TOP]) : 1'b0;
    end
  end

  assign carry_init = 1'b0;
`else
  // Exact mode: the ripple slice result is used unchanged.
  always_comb begin
    s_d  = s_x;
    co_d = co_x;
  end

  assign carry_init = cin;
`endif

  // Merge the freshly computed slice into the running sum.
  always_comb begin
    sum_d              = sum_q;
    sum_d[base +: CHUNK] = s_d;
  end

  // Control FSM and datapath; handshake outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= carry_init;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= co_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q      <= co_d;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // No bypass to IDLE-accept: a new operation waits one more edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked: scoreboard bench; an 8/4 instance for directed cases and a
// 32/8 instance for back-to-back operations under random out_ready stalls.
module tb_adder_chunked;

`ifdef ADDER_CHUNKED_APPROX_LSB_EN
  localparam bit APX = 1'b1;
`else
  localparam bit APX = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-bit instance
  logic       rst8_n, iv8, ir8, ov8, or8, cin8, co8;
  logic [7:0] a8, b8, s8;
  logic [8:0] q8[$];

  adder_chunked #(.WIDTH(8), .CHUNK(4), .APPROX_BITS(4)) u8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8)
  );

  // 32-bit instance
  logic        rst32_n, iv32, ir32, ov32, cin32, co32;
  logic        or32 = 1'b1;
  logic        rnd32 = 1'b0;
  logic [31:0] a32, b32, s32;
  logic [32:0] q32[$];
  int          n32 = 0;

  adder_chunked #(.WIDTH(32), .CHUNK(8), .APPROX_BITS(8)) u32 (
    .clk(clk), .rst_n(rst32_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(ov32), .out_ready(or32),
    .sum(s32), .cout(co32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitors: pop and compare on each output handshake.
  always @(negedge clk) begin
    if (rst8_n && ov8 && or8) begin
      if (q8.size() == 0) chk("res8_unexpected", {co8, s8}, 64'hDEAD);
      else                chk("res8", {co8, s8}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst32_n && ov32 && or32) begin
      n32++;
      if (q32.size() == 0) chk("res32_unexpected", {co32, s32}, 64'hDEAD);
      else                 chk("res32", {co32, s32}, q32.pop_front());
    end
  end

  // Random consumer stalls for the 32-bit stream.
  always @(posedge clk) begin
    #1;
    or32 = rnd32 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] exp, input bit push);
    int n;
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ir8) break;
    end
    if (!ir8) chk("accept8_timeout", 64'd0, 64'd1);
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    iv8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  task automatic drain8;
    or8 = 1'b1;
    for (int n = 0; n < 100 && q8.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain8", 64'(q8.size()), 64'd0);
    or8 = 1'b0;
  endtask

  logic [31:0] va[8] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h000000FF,
                         32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF};
  logic [31:0] vb[8] = '{32'h00000001, 32'h11111111, 32'h80000000, 32'h000000FF,
                         32'h01234567, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
  logic        vc[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [32:0] ve[8] = '{33'h1_00000000, 33'h0_2345678A, 33'h1_00000000, 33'h0_000001FF,
                         33'h0_DFD10456, 33'h1_FFFFFFFF, 33'h0_00000001, 33'h0_80000000};
  logic [32:0] vx[8] = '{33'h0_FFFFFFFF, 33'h0_23456779, 33'h1_00000000, 33'h0_000001FF,
                         33'h0_DFD103EF, 33'h1_FFFFFFFF, 33'h0_00000000, 33'h0_7FFFFFFF};

  initial begin
    rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst32_n = 1'b0; iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    #12;
    chk("rst8_in_ready",  64'(ir8), 64'd1);
    chk("rst8_out_valid", 64'(ov8), 64'd0);
    chk("rst8_result",    64'({co8, s8}), 64'd0);
    chk("rst32_in_ready", 64'(ir32), 64'd1);
    chk("rst32_result",   64'({co32, s32}), 64'd0);
    rst8_n = 1'b1; rst32_n = 1'b1;
    @(posedge clk); #1;

    // FF+01: carry out of the top, valid two edges after acceptance.
    send8(8'hFF, 8'h01, 1'b0, APX ? 9'h0FF : 9'h100, 1'b1);
    @(negedge clk); chk("lat_e0", 64'(ov8), 64'd0);
    @(negedge clk); chk("lat_e1", 64'(ov8), 64'd0);
    @(negedge clk); chk("lat_e2", 64'(ov8), 64'd1);
    drain8();

    // 12+34+1: busy through RUN and DONE.
    send8(8'h12, 8'h34, 1'b1, APX ? 9'h046 : 9'h047, 1'b1);
    repeat (3) begin
      @(negedge clk); chk("busy_in_ready", 64'(ir8), 64'd0);
    end
    drain8();

    // Output stall with new operands offered: held result, no acceptance.
    send8(8'hA5, 8'h5A, 1'b0, 9'h0FF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    iv8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(ov8), 64'd1);
      chk("stall_in_ready",  64'(ir8), 64'd0);
      chk("stall_result",    64'({co8, s8}), 64'h0FF);
    end
    @(posedge clk); #1; or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    chk("idle_after_hs", 64'(ir8), 64'd1);
    q8.push_back(9'h077);
    @(posedge clk); #1;
    chk("accept_next_edge", 64'(ir8), 64'd0);
    iv8 = 1'b0;
    drain8();

    // Reset in the middle of RUN discards the partial result.
    send8(8'hF0, 8'h10, 1'b0, 9'h000, 1'b0);
    @(posedge clk); #1;
    rst8_n = 1'b0; #1;
    chk("midrst_out_valid", 64'(ov8), 64'd0);
    chk("midrst_sum",       64'(s8),  64'd0);
    chk("midrst_cout",      64'(co8), 64'd0);
    chk("midrst_in_ready",  64'(ir8), 64'd1);
    @(posedge clk); #1; rst8_n = 1'b1;
    send8(8'h01, 8'h01, 1'b0, APX ? 9'h001 : 9'h002, 1'b1);
    drain8();

    // Carry across the approximate boundary and cin handling.
    send8(8'h08, 8'h08, 1'b0, APX ? 9'h018 : 9'h010, 1'b1);
    drain8();
    send8(8'h0F, 8'h01, 1'b1, APX ? 9'h00F : 9'h011, 1'b1);
    drain8();
    send8(8'h80, 8'h80, 1'b1, APX ? 9'h100 : 9'h101, 1'b1);
    drain8();

    // 32-bit back-to-back stream with random consumer stalls.
    rnd32 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n;
      a32 = va[i]; b32 = vb[i]; cin32 = vc[i]; iv32 = 1'b1;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (ir32) break;
      end
      if (!ir32) chk("accept32_timeout", 64'd0, 64'd1);
      q32.push_back(APX ? vx[i] : ve[i]);
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    for (int n = 0; n < 500 && q32.size() != 0; n++) @(posedge clk);
    #2;
    rnd32 = 1'b0;
    chk("drain32", 64'(q32.size()), 64'd0);
    repeat (4) @(posedge clk);
    chk("count32", 64'(n32), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
